// File: rtl/rf_seq_pkg.sv
// Shared constants for the register-file sequencer: widths, opcodes, state encoding.
package rf_seq_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op <= OP_SHL);
    endfunction

endpackage

// File: rtl/rf_sequencer_if.sv
// Bundle of the sequencer's instruction and register-file signals for environments
// that prefer a single handle; the sequencer itself keeps its flat legacy ports.
interface rf_sequencer_if;
    import rf_seq_pkg::*;

    logic                instr_valid;
    logic                instr_ready;
    logic [2:0]          instr_op;
    logic [ADDR_W-1:0]   instr_rd;
    logic [ADDR_W-1:0]   instr_rs1;
    logic [ADDR_W-1:0]   instr_rs2;
    logic [DATA_W-1:0]   instr_imm;
    logic [ADDR_W-1:0]   rf_num_R1;
    logic [ADDR_W-1:0]   rf_num_R2;
    logic [ADDR_W-1:0]   rf_W1;
    logic [DATA_W-1:0]   rf_Din;
    logic                rf_WE;
    logic [DATA_W-1:0]   rf_Dout_1;
    logic [DATA_W-1:0]   rf_Dout_2;
    logic                done;
    logic [DATA_W-1:0]   result;
    logic                flag_c;
    logic                flag_z;

    // Instruction issuer plus register file
    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        output rf_Dout_1, rf_Dout_2,
        input  instr_ready, rf_num_R1, rf_num_R2, rf_W1, rf_Din, rf_WE,
        input  done, result, flag_c, flag_z
    );

    // Sequencer side
    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        input  rf_Dout_1, rf_Dout_2,
        output instr_ready, rf_num_R1, rf_num_R2, rf_W1, rf_Din, rf_WE,
        output done, result, flag_c, flag_z
    );

endinterface

// File: rtl/rf_seq_alu.sv
// Combinational ALU: result and carry/borrow for the six register-register ops.
module rf_seq_alu
    import rf_seq_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_o,
    output logic              c_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic [DATA_W:0] shl;

    // Bit 16 of the 17-bit shift holds the last bit pushed out of the word
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};
    assign shl  = {1'b0, a_i} << b_i[3:0];

    always_comb begin
        res_o = '0;
        c_o   = 1'b0;
        case (op_i)
            OP_ADD: begin res_o = sum[DATA_W-1:0];  c_o = sum[DATA_W];  end
            OP_SUB: begin res_o = diff[DATA_W-1:0]; c_o = diff[DATA_W]; end
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_SHL: begin res_o = shl[DATA_W-1:0];  c_o = shl[DATA_W];  end
            default: ;
        endcase
    end

endmodule

// File: rtl/rf_sequencer.sv
// Four-state instruction sequencer: reads two registers, runs the ALU, writes back.
module rf_sequencer
    import rf_seq_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] rf_num_R1,
    output logic [ADDR_W-1:0] rf_num_R2,
    output logic [ADDR_W-1:0] rf_W1,
    output logic [DATA_W-1:0] rf_Din,
    output logic              rf_WE,
    input  logic [DATA_W-1:0] rf_Dout_1,
    input  logic [DATA_W-1:0] rf_Dout_2,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_c,
    output logic              flag_z
);

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              c_q, c_d, z_q, z_d;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              accept;

    rf_seq_alu u_alu (
        .op_i  (op_q),
        .a_i   (rf_Dout_1),
        .b_i   (rf_Dout_2),
        .res_o (alu_res),
        .c_o   (alu_c)
    );

    assign instr_ready = (state_q == S_IDLE) & ~RST;
    assign accept      = instr_valid & instr_ready;

    // The immediate is consumed on the acceptance edge straight into result,
    // so it needs no separate holding register.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d  = instr_op;
                rd_d  = instr_rd;
                rs1_d = instr_rs1;
                rs2_d = instr_rs2;
                if (is_alu_op(instr_op)) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_WB;
                    if (instr_op == OP_LDI) begin
                        result_d = instr_imm;
                        c_d      = 1'b0;
                        z_d      = (instr_imm == '0);
                    end
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                state_d  = S_WB;
                result_d = alu_res;
                c_d      = alu_c;
                z_d      = (alu_res == '0);
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
        end
    end

    assign rf_num_R1 = rs1_q;
    assign rf_num_R2 = rs2_q;
    assign rf_W1     = rd_q;
    assign rf_Din    = result_q;
    assign rf_WE     = (state_q == S_WB) & (op_q != OP_NOP) & ~RST;
    assign done      = (state_q == S_WB);
    assign result    = result_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed and random checks of rf_sequencer against an instruction-level model.
module tb_rf_sequencer;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    rf_sequencer_if bus ();

    rf_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .instr_valid (bus.instr_valid),
        .instr_ready (bus.instr_ready),
        .instr_op    (bus.instr_op),
        .instr_rd    (bus.instr_rd),
        .instr_rs1   (bus.instr_rs1),
        .instr_rs2   (bus.instr_rs2),
        .instr_imm   (bus.instr_imm),
        .rf_num_R1   (bus.rf_num_R1),
        .rf_num_R2   (bus.rf_num_R2),
        .rf_W1       (bus.rf_W1),
        .rf_Din      (bus.rf_Din),
        .rf_WE       (bus.rf_WE),
        .rf_Dout_1   (bus.rf_Dout_1),
        .rf_Dout_2   (bus.rf_Dout_2),
        .done        (bus.done),
        .result      (bus.result),
        .flag_c      (bus.flag_c),
        .flag_z      (bus.flag_z)
    );

    always #5 CLK = ~CLK;

    // Register file environment: synchronous write, registered read
    logic [15:0] rf_mem [8] = '{default: 16'h0000};
    always @(posedge CLK) begin
        if (bus.rf_WE) rf_mem[bus.rf_W1] <= bus.rf_Din;
        bus.rf_Dout_1 <= rf_mem[bus.rf_num_R1];
        bus.rf_Dout_2 <= rf_mem[bus.rf_num_R2];
    end

    // Instruction-level reference model
    int unsigned exp_regs [8] = '{default: 0};
    int unsigned m_res = 0;
    int unsigned m_c   = 0;
    int unsigned m_z   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] imm,
                         input bit hold, input bit rst_wb);
        int unsigned a, b, s, sh, r, c, lat;
        int n;
        @(negedge CLK);
        n = 0;
        while (bus.instr_ready !== 1'b1) begin
            n++;
            if (n > 20) begin
                chk("ready_timeout", {31'd0, bus.instr_ready}, 32'd1);
                return;
            end
            @(negedge CLK);
        end
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs1   = rs1;
        bus.instr_rs2   = rs2;
        bus.instr_imm   = imm;
        @(posedge CLK);
        #1;
        if (!hold) bus.instr_valid = 1'b0;

        a = exp_regs[rs1];
        b = exp_regs[rs2];
        r = m_res;
        c = m_c;
        case (op)
            3'd0: begin s = a + b; r = s % 65536; c = (s > 65535) ? 1 : 0; end
            3'd1: begin r = (a + 65536 - b) % 65536; c = (a < b) ? 1 : 0; end
            3'd2: begin r = a & b; c = 0; end
            3'd3: begin r = a | b; c = 0; end
            3'd4: begin r = a ^ b; c = 0; end
            3'd5: begin
                sh = b % 16;
                r  = (a * (32'd1 << sh)) % 65536;
                c  = (sh == 0) ? 0 : ((a >> (16 - sh)) & 1);
            end
            3'd6: begin r = imm; c = 0; end
            default: ;
        endcase
        lat = (op <= 3'd5) ? 3 : 1;

        for (int unsigned k = 1; k < lat; k++) begin
            @(negedge CLK);
            chk("busy_ready", {31'd0, bus.instr_ready}, 32'd0);
            chk("busy_done",  {31'd0, bus.done},        32'd0);
            chk("busy_we",    {31'd0, bus.rf_WE},       32'd0);
        end
        @(negedge CLK);
        chk("wb_ready", {31'd0, bus.instr_ready}, 32'd0);

        if (rst_wb) begin
            RST = 1'b1;
            #1;
            chk("rst_wb_we", {31'd0, bus.rf_WE}, 32'd0);
            @(posedge CLK);
            #1;
            RST = 1'b0;
            m_res = 0; m_c = 0; m_z = 0;
            @(negedge CLK);
            chk("rst_ready",  {31'd0, bus.instr_ready}, 32'd1);
            chk("rst_result", {16'd0, bus.result},      32'd0);
            chk("rst_c",      {31'd0, bus.flag_c},      32'd0);
            chk("rst_z",      {31'd0, bus.flag_z},      32'd0);
            return;
        end

        chk("wb_done", {31'd0, bus.done}, 32'd1);
        chk("wb_we",   {31'd0, bus.rf_WE}, (op == 3'd7) ? 32'd0 : 32'd1);
        if (op != 3'd7) begin
            m_res = r;
            m_c   = c;
            m_z   = (r == 0) ? 1 : 0;
            exp_regs[rd] = r;
            chk("wb_w1",  {29'd0, bus.rf_W1}, {29'd0, rd});
            chk("wb_din", {16'd0, bus.rf_Din}, m_res);
        end
        chk("wb_result", {16'd0, bus.result}, m_res);
        chk("wb_c",      {31'd0, bus.flag_c}, m_c);
        chk("wb_z",      {31'd0, bus.flag_z}, m_z);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_op    = 3'd7;
        bus.instr_rd    = '0;
        bus.instr_rs1   = '0;
        bus.instr_rs2   = '0;
        bus.instr_imm   = '0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_ready_low", {31'd0, bus.instr_ready}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("reset_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("reset_result", {16'd0, bus.result}, 32'd0);
        chk("reset_c", {31'd0, bus.flag_c}, 32'd0);
        chk("reset_z", {31'd0, bus.flag_z}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_we", {31'd0, bus.rf_WE}, 32'd0);

        // Load, carry-out add to zero, borrow subtract, shift with carry
        issue(3'd6, 3'd1, 3'd0, 3'd0, 16'h1234, 1'b0, 1'b0);
        issue(3'd6, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1'b0, 1'b0);
        issue(3'd6, 3'd2, 3'd0, 3'd0, 16'h0001, 1'b0, 1'b0);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b0);
        issue(3'd1, 3'd4, 3'd2, 3'd1, 16'h0000, 1'b0, 1'b0);
        issue(3'd5, 3'd5, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b0);

        // instr_valid held high across two back-to-back instructions
        issue(3'd6, 3'd6, 3'd0, 3'd0, 16'h0005, 1'b1, 1'b0);
        issue(3'd0, 3'd6, 3'd6, 3'd6, 16'h0000, 1'b1, 1'b0);
        bus.instr_valid = 1'b0;
        chk("held_add_r6", exp_regs[6], 32'h000A);

        issue(3'd7, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0);

        // Reset during write-back loses the XOR; r7 must still read back
        issue(3'd6, 3'd7, 3'd0, 3'd0, 16'hBEEF, 1'b0, 1'b0);
        issue(3'd4, 3'd7, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b1);
        issue(3'd3, 3'd0, 3'd7, 3'd7, 16'h0000, 1'b0, 1'b0);
        chk("r7_readback", {16'd0, bus.rf_Din}, 32'h0000BEEF);

        for (int i = 0; i < 60; i++) begin
            logic [15:0] imm;
            imm = 16'($urandom);
            if ($urandom_range(0, 7) == 0) imm = 16'h0000;
            issue(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
                  imm, 1'b0, 1'b0);
        end

        repeat (2) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_sequencer.md
RF_SEQUENCER -- requirements
Module: rf_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port instr_valid, input, 1 bit: an instruction is offered.
REQ-004 SHALL have port instr_ready, output, 1 bit: the sequencer accepts the instruction this cycle.
REQ-005 SHALL have port instr_op, input, 3 bits: opcode 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 LDI, 111 NOP.
REQ-006 SHALL have ports instr_rd, instr_rs1 and instr_rs2, inputs, 3 bits each: destination and source register numbers.
REQ-007 SHALL have port instr_imm, input, 16 bits: immediate operand for LDI.
REQ-008 SHALL have ports rf_num_R1 and rf_num_R2, outputs, 3 bits each: register-file read addresses.
REQ-009 SHALL have ports rf_W1 (output, 3 bits), rf_Din (output, 16 bits) and rf_WE (output, 1 bit): register-file write address, write data and write enable.
REQ-010 SHALL have ports rf_Dout_1 and rf_Dout_2, inputs, 16 bits each: register-file read data, registered one cycle after the address.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have ports result (output, 16 bits), flag_c (output, 1 bit) and flag_z (output, 1 bit): last result, carry/borrow flag, zero flag.

Function
REQ-013 SHALL implement states IDLE, READ, EXEC and WB.
REQ-014 SHALL drive instr_ready = (state==IDLE) & ~RST.
REQ-015 SHALL, when instr_valid & instr_ready, latch op, rd, rs1, rs2 and imm; instruction inputs are ignored at all other times.
REQ-016 SHALL, on acceptance, transition IDLE->READ for ALU ops (000-101) and IDLE->WB for LDI and NOP.
REQ-017 SHALL drive rf_num_R1 and rf_num_R2 from the latched rs1 and rs2 in every state.
REQ-018 SHALL transition READ->EXEC, EXEC->WB and WB->IDLE unconditionally.
REQ-019 SHALL, in EXEC, compute from rf_Dout_1 (A) and rf_Dout_2 (B) and register the value into result at the EXEC->WB edge:
- ADD: A+B, flag_c = bit 16 of the sum.
- SUB: A-B, flag_c = borrow (A<B).
- AND, OR, XOR: bitwise.
- SHL: A << B[3:0], flag_c = last bit shifted out (0 when B[3:0]=0).
REQ-020 SHALL, for LDI, register result=imm at the IDLE->WB edge and clear flag_c.
REQ-021 SHALL set flag_z = (new result==0) whenever result is updated; NOP SHALL leave result, flag_c and flag_z unchanged.
REQ-022 SHALL, in WB, drive rf_W1 = latched rd and rf_Din = result, and drive rf_WE = (state==WB) & (op!=NOP) & ~RST; rf_WE SHALL be 0 in all other states.
REQ-023 SHALL assert done for exactly the WB cycle, for every op including NOP.
REQ-024 SHALL give latency (acceptance edge to WB cycle) of 3 cycles for ALU ops and 1 cycle for LDI/NOP.
REQ-025 SHALL provide a minimum of one IDLE cycle between instructions, so a read issued by the following instruction observes the preceding write-back.
REQ-026 SHALL keep instr_ready low throughout READ, EXEC and WB even when instr_valid is held high.

Reset
REQ-027 SHALL, when RST is high at a rising edge, set state=IDLE and result=0, flag_c=0, flag_z=0 and clear all latched instruction fields to 0.
REQ-028 SHALL, when RST is asserted mid-operation, abandon the instruction; an RST coinciding with WB SHALL suppress the write (rf_WE=0) and the instruction SHALL be lost.

Structure
REQ-029 SHALL take the opcode constants, the state encoding and DATA_W=16 / ADDR_W=3 from a shared package rf_seq_pkg.
REQ-030 SHALL place the combinational ALU of REQ-019 in a single sub-module rf_seq_alu.

Verification
REQ-031 SHALL cover: reset, then LDI r1,0x1234 -> one cycle after acceptance rf_WE=1, rf_W1=1, rf_Din=0x1234, done=1, flag_z=0.
REQ-032 SHALL cover: LDI r1,0xFFFF; LDI r2,0x0001; ADD r3,r1,r2 -> 3 cycles after the ADD is accepted rf_Din=0x0000, flag_c=1, flag_z=1.
REQ-033 SHALL cover: SUB r4,r2,r1 (1-0xFFFF) -> rf_Din=0x0002, flag_c=1; then SHL r5,r1,r2 -> 0xFFFE, flag_c=1.
REQ-034 SHALL cover: instr_valid held high with LDI r6,0x0005 then ADD r6,r6,r6 -> instr_ready low in non-IDLE states; the ADD writes 0x000A to r6.
REQ-035 SHALL cover: RST pulsed during the WB cycle of XOR r7,... -> rf_WE=0, next cycle state=IDLE, instr_ready=1, result=0, r7 unchanged on readback.
REQ-036 SHALL cover: NOP after a nonzero result -> done pulses, rf_WE stays 0, result/flag_c/flag_z unchanged.
